// File: rtl/l2_mem_pkg.sv
// l2_mem_pkg: shared FSM state, block type and address alignment for the L2 miss queue
package l2_mem_pkg;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_BLOCK_SIZE = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef logic [DEF_BLOCK_SIZE-1:0][DEF_DATA_WIDTH-1:0] block_t;
    function automatic logic [63:0] block_align(input logic [63:0] addr, input int off_bits);
        return addr & ~((64'd1 << off_bits) - 64'd1);
    endfunction
endpackage

// File: rtl/l2_miss_queue_if.sv
// l2_miss_queue_if: L2 request/response channel plus memory port of the miss queue
interface l2_miss_queue_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 16,
    parameter int DEPTH = 4,
    parameter int ID_WIDTH = 2
);
    logic req_valid, req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [ID_WIDTH-1:0] req_id;
    logic resp_valid, resp_ready, resp_err;
    logic [ID_WIDTH-1:0] resp_id;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] resp_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic mem_read, mem_write, mem_ready, mem_hit;
    logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in, mem_data_out;
    logic [$clog2(DEPTH):0] occupancy;
    modport master (
        output req_valid, req_addr, req_id, resp_ready, mem_data_out, mem_ready, mem_hit,
        input req_ready, resp_valid, resp_id, resp_addr, resp_data, resp_err,
        input mem_addr, mem_read, mem_write, mem_data_in, occupancy
    );
    modport slave (
        input req_valid, req_addr, req_id, resp_ready, mem_data_out, mem_ready, mem_hit,
        output req_ready, resp_valid, resp_id, resp_addr, resp_data, resp_err,
        output mem_addr, mem_read, mem_write, mem_data_in, occupancy
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: in-order queue with head peek; pointers carry an extra wrap bit for full/empty
module sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic pop,
    input logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [$clog2(DEPTH):0] count,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk)
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    always_ff @(posedge clk)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
endmodule

// File: rtl/l2_miss_queue.sv
// l2_miss_queue: buffers L2 block misses, issues them to memory one at a time, returns data or timeout error
module l2_miss_queue import l2_mem_pkg::*; #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BLOCK_SIZE = 16,
    parameter int DEPTH = 4,
    parameter int ID_WIDTH = 2,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst_n,
    l2_miss_queue_if.slave bus
);
    localparam int OFF = $clog2(BLOCK_SIZE);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int EW = ID_WIDTH + ADDR_WIDTH;
    state_t state;
    logic [TW-1:0] timer;
    logic [EW-1:0] head;
    logic [ADDR_WIDTH-1:0] head_addr, req_blk;
    logic [ID_WIDTH-1:0] head_id;
    logic full, empty, push, pop, hit;
    assign req_blk = ADDR_WIDTH'(block_align(64'(bus.req_addr), OFF));
    assign {head_id, head_addr} = head;
    assign bus.req_ready = !full;
    assign push = bus.req_valid && !full;
    assign pop = bus.resp_valid && bus.resp_ready;
    assign hit = bus.mem_ready && bus.mem_hit;
    assign bus.mem_write = 1'b0;
    assign bus.mem_data_in = '0;
    // the head stays queued while in service so occupancy counts it until the response pops
    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .pop(pop),
        .din({bus.req_id, req_blk}),
        .head(head),
        .count(bus.occupancy),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk)
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            bus.mem_read <= 1'b0;
            bus.mem_addr <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_err <= 1'b0;
            bus.resp_data <= '0;
            bus.resp_id <= '0;
            bus.resp_addr <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    state <= ISSUE;
                    bus.mem_read <= 1'b1;
                    bus.mem_addr <= head_addr;
                end
                ISSUE: begin
                    state <= WAIT;
                    bus.mem_read <= 1'b0;
                    timer <= '0;
                end
                // a hit on the final wait cycle still wins over the timeout
                WAIT: if (hit || timer == TW'(TIMEOUT - 1)) begin
                    state <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err <= !hit;
                    bus.resp_data <= hit ? bus.mem_data_out : '0;
                    bus.resp_id <= head_id;
                    bus.resp_addr <= head_addr;
                end else timer <= timer + 1'b1;
                RESP: if (bus.resp_ready) begin
                    state <= IDLE;
                    bus.resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: doc/l2_miss_queue.md
# l2_miss_queue

Miss queue between the L2 cache and main memory. It accepts block-read requests from L2 and buffers them in order. It issues each request to memory as a single-cycle read pulse, then waits for the memory's ready/hit response. It returns the fetched block to L2 with the original request ID, or an error response if memory does not answer within TIMEOUT cycles.

## Interface
- DATA_WIDTH, 32, word width
- ADDR_WIDTH, 32, byte/word address width as used by memory
- BLOCK_SIZE, 16, words per block; power of two
- DEPTH, 4, request queue entries; power of two, ≥2
- ID_WIDTH, 2, request tag width
- TIMEOUT, 255, max cycles in WAIT before error; ≥1

- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low
- req_valid  in  1  L2 request valid
- req_ready  out  1  queue can accept
- req_addr  in  ADDR_WIDTH  miss address (any offset)
- req_id  in  ID_WIDTH  request tag
- resp_valid  out  1  response valid
- resp_ready  in  1  L2 accepts response
- resp_id  out  ID_WIDTH  tag of completed request
- resp_addr  out  ADDR_WIDTH  block-aligned address
- resp_data  out  BLOCK_SIZE×DATA_WIDTH  fetched block
- resp_err  out  1  timeout occurred
- mem_addr  out  ADDR_WIDTH  block-aligned address to memory
- mem_read  out  1  one-cycle read strobe
- mem_write  out  1  tied 0
- mem_data_in  out  BLOCK_SIZE×DATA_WIDTH  tied 0
- mem_data_out  in  BLOCK_SIZE×DATA_WIDTH  memory block data
- mem_ready  in  1  memory response pulse
- mem_hit  in  1  memory response valid
- occupancy  out  $clog2(DEPTH)+1  queued entries, including the one in service

## Operation
- Push occurs when req_valid && req_ready. The entry stored is {req_id, req_addr with low $clog2(BLOCK_SIZE) bits zeroed}.
- req_ready = (occupancy != DEPTH). This is combinational from the registered count. No push occurs when full, even in a cycle where a pop happens.
- The head entry stays in the FIFO until its response handshake completes. Pop happens on resp_valid && resp_ready.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE → ISSUE when FIFO is non-empty.
  - ISSUE: mem_read=1 for exactly this cycle, mem_addr = head address. Go to WAIT and clear the timer.
  - WAIT: mem_addr holds and mem_read=0. On mem_ready && mem_hit, capture mem_data_out into resp_data, set resp_err=0, go to RESP. Otherwise the timer increments. When the timer reaches TIMEOUT: resp_data=0, resp_err=1, go to RESP.
  - RESP: resp_valid=1, and resp_id/resp_addr come from the head. Hold all outputs stable until resp_ready. On the handshake, pop and go to IDLE.
- mem_ready arriving outside WAIT is ignored. mem_ready without mem_hit is ignored, and the timer continues.
- resp_data, resp_err, resp_id and resp_addr are registered. They are only meaningful while resp_valid=1.

## Timing
- Reset values: req_ready=1 (after reset), resp_valid=0, resp_err=0, resp_data=0, resp_id=0, resp_addr=0, mem_read=0, mem_addr=0, occupancy=0, FSM=IDLE, timer=0.
- Reset mid-operation discards all entries and any captured data. Memory shares rst_n, so no stale response is expected. Any stale mem_ready after reset is ignored because the FSM is in IDLE.
- Latency, empty queue: push at edge E0 → ISSUE during the cycle after E1 → memory samples mem_read at E2. If memory raises mem_ready in cycle C, resp_valid rises in cycle C+1.
- Back-to-back: the next ISSUE happens at earliest 2 cycles after the pop edge (RESP→IDLE→ISSUE).
- Timer width is $clog2(TIMEOUT+1). The timeout response is asserted TIMEOUT+1 cycles after ISSUE.
- Push into an empty queue and FSM sampling of non-empty are on different edges. There is no bypass.

## Structure
- Package l2_mem_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT, RESP}
  - the block typedef (BLOCK_SIZE×DATA_WIDTH)
  - the block-alignment function
- Sub-module sync_fifo (width ID_WIDTH+ADDR_WIDTH, DEPTH) provides push/pop, head peek, count, full and empty. Pointers wrap modulo DEPTH using an extra bit for full/empty detection.

## Test plan
- Single request, stub memory with latency 5: req_addr=0x1237, id=2 → mem_read pulses once with mem_addr=0x1230. resp_valid arrives 1 cycle after mem_ready with resp_id=2, resp_addr=0x1230, resp_data[i]=0x1230+i, resp_err=0.
- Fill the queue with ids 0..3 and addresses 0x00, 0x10, 0x20, 0x30 while memory is stalled → req_ready=0 at occupancy 4. Responses return in order 0,1,2,3, and each mem_read is issued only after the previous pop.
- Backpressure: hold resp_ready=0 for 10 cycles → resp_* stays stable, mem_read does not pulse again, and occupancy holds.
- Memory never responds, TIMEOUT=20 → resp_err=1, resp_data=0, resp_valid asserted 21 cycles after ISSUE. The next entry is then served normally.
- Reset asserted during WAIT with 3 entries queued → next cycle occupancy=0, resp_valid=0, mem_read=0. A late mem_ready pulse produces no response.
- Push while full coinciding with a pop → push rejected (req_ready=0), occupancy drops to 3, accepted the following cycle.
